imm_extend_pipe: RTL and testbench

//  Registered, parametrised immediate extender with valid/ready handshake.

---
 rtl/imm_extend_pipe.sv | 125 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender (sign/zero/branch/upper)
// with a 2-entry skid buffer. Define IMM_EXT_CNT_EN to enable Out_cnt.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [IN_W-1:0]  In_imm,
    input  logic [1:0]       In_mode,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [OUT_W-1:0] Out_imm,
    output logic [31:0]      Out_cnt
);

    generate
        if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_width
            $error("imm_extend_pipe: IN_W must be in 1..OUT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_main;
    logic [OUT_W-1:0] r_skid;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_ext;
    logic             w_acc;
    logic             w_take;

    assign w_sext = OUT_W'($signed(In_imm));
    assign w_zext = OUT_W'(In_imm);
    assign w_acc  = In_valid & r_in_ready;
    assign w_take = r_out_valid & Out_ready;

    // Select the extension of the incoming immediate by mode.
    always_comb begin
        w_ext = w_sext;
        unique case (In_mode)
            2'd0: w_ext = w_sext;
            2'd1: w_ext = w_zext;
            2'd2: w_ext = w_sext << 2;
            2'd3: w_ext = w_zext << (OUT_W - IN_W);
        endcase
    end

    // Occupancy FSM: main holds the presented result, skid absorbs one more.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_main      <= w_ext;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && Out_ready) begin
                        r_main <= w_ext;
                    end else if (w_acc) begin
                        r_skid     <= w_ext;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_FULL;
                    end else if (Out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (Out_ready) begin
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMM_EXT_CNT_EN
    logic [31:0] r_cnt;

    // Count completed output transfers; wraps naturally at 2^32.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= 32'd0;
        end else if (w_take) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign Out_cnt = r_cnt;
`else
    assign Out_cnt = 32'd0;
`endif

    assign In_ready  = r_in_ready;
    assign Out_valid = r_out_valid;
    assign Out_imm   = r_main;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: randomized scoreboard bench for imm_extend_pipe
// plus direct parameter-sweep instances (12->32 and 16->16).
module tb_imm_extend_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        In_valid = 1'b0;
    logic        In_ready;
    logic [15:0] In_imm = '0;
    logic [1:0]  In_mode = '0;
    logic        Out_valid;
    logic        Out_ready = 1'b0;
    logic [31:0] Out_imm;
    logic [31:0] Out_cnt;

    logic        p_valid = 1'b0;
    logic        p_ready = 1'b1;
    logic [1:0]  p_mode = '0;
    logic [11:0] p12_imm = '0;
    logic [15:0] p16_imm = '0;
    logic        p12_in_ready, p12_out_valid;
    logic        p16_in_ready, p16_out_valid;
    logic [31:0] p12_out_imm, p12_cnt, p16_cnt;
    logic [15:0] p16_out_imm;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;
    logic [31:0] sb_q[$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_imm = '0;

    always #5 Clk = ~Clk;

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .In_valid(In_valid), .In_ready(In_ready),
        .In_imm(In_imm), .In_mode(In_mode),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Out_imm(Out_imm), .Out_cnt(Out_cnt)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(32)) dut12 (
        .Clk(Clk), .Rst_n(Rst_n),
        .In_valid(p_valid), .In_ready(p12_in_ready),
        .In_imm(p12_imm), .In_mode(p_mode),
        .Out_valid(p12_out_valid), .Out_ready(p_ready),
        .Out_imm(p12_out_imm), .Out_cnt(p12_cnt)
    );

    imm_extend_pipe #(.IN_W(16), .OUT_W(16)) dut16 (
        .Clk(Clk), .Rst_n(Rst_n),
        .In_valid(p_valid), .In_ready(p16_in_ready),
        .In_imm(p16_imm), .In_mode(p_mode),
        .Out_valid(p16_out_valid), .Out_ready(p_ready),
        .Out_imm(p16_out_imm), .Out_cnt(p16_cnt)
    );

    // Reference: integer arithmetic modulo 2^out_w.
    function automatic logic [31:0] ref_ext(int in_w, int out_w,
                                            longint imm, int mode);
        longint half = longint'(1) << (in_w - 1);
        longint s    = (imm >= half) ? imm - 2 * half : imm;
        longint m    = longint'(1) << out_w;
        longint r;
        case (mode)
            0:       r = s;
            1:       r = imm;
            2:       r = s * 4;
            default: r = imm * (longint'(1) << (out_w - in_w));
        endcase
        r = r % m;
        if (r < 0) r = r + m;
        return r[31:0];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(output bit acc);
        @(negedge Clk);
        acc = In_valid && In_ready;
        if (acc)
            sb_q.push_back(ref_ext(IN_W, OUT_W, longint'(In_imm), int'(In_mode)));
        @(posedge Clk);
        #1;
    endtask

    task automatic send_one(string name, logic [15:0] imm,
                            logic [1:0] mode, logic [31:0] exp);
        bit acc;
        In_valid = 1'b1;
        In_imm   = imm;
        In_mode  = mode;
        step(acc);
        In_valid = 1'b0;
        chk({name, "_acc"}, 32'(acc), 32'd1);
        @(negedge Clk);
        chk({name, "_valid"}, 32'(Out_valid), 32'd1);
        chk(name, Out_imm, exp);
        @(posedge Clk);
        #1;
    endtask

    task automatic sweep_one(logic [11:0] i12, logic [15:0] i16,
                             logic [1:0] mode);
        p_valid = 1'b1;
        p12_imm = i12;
        p16_imm = i16;
        p_mode  = mode;
        @(posedge Clk);
        #1;
        p_valid = 1'b0;
        chk("p12_valid", 32'(p12_out_valid), 32'd1);
        chk("p16_valid", 32'(p16_out_valid), 32'd1);
        chk("p12_imm", p12_out_imm, ref_ext(12, 32, longint'(i12), int'(mode)));
        chk("p16_imm", 32'(p16_out_imm), ref_ext(16, 16, longint'(i16), int'(mode)));
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    always @(negedge Clk) begin
        if (!Rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(Out_valid), 32'd1);
                chk("hold_imm", Out_imm, prev_imm);
            end
`ifdef IMM_EXT_CNT_EN
            chk("out_cnt", Out_cnt, 32'(n_xfer));
`else
            chk("out_cnt_tied", Out_cnt, 32'd0);
`endif
            if (Out_valid && Out_ready) begin
                if (sb_q.size() == 0)
                    chk("unexpected_out", Out_imm, 32'hxxxxxxxx);
                else
                    chk("sb_data", Out_imm, sb_q.pop_front());
                n_xfer++;
            end
            prev_stall = Out_valid && !Out_ready;
            prev_imm   = Out_imm;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: timeout reached, run stuck");
        $fatal(1);
    end

    initial begin
        bit acc;
        bit hold;
        logic [31:0] last_exp;

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_out_valid", 32'(Out_valid), 32'd0);
        chk("rst_out_imm", Out_imm, 32'd0);
        chk("rst_out_cnt", Out_cnt, 32'd0);
        Rst_n = 1'b1;
        chk("rst_in_ready", 32'(In_ready), 32'd1);

        // Fixed mode vectors, 16 -> 32.
        Out_ready = 1'b1;
        send_one("m0_8001", 16'h8001, 2'd0, 32'hFFFF8001);
        send_one("m1_8001", 16'h8001, 2'd1, 32'h00008001);
        send_one("m2_8001", 16'h8001, 2'd2, 32'hFFFE0004);
        send_one("m3_8001", 16'h8001, 2'd3, 32'h80010000);
        send_one("m0_7fff", 16'h7FFF, 2'd0, 32'h00007FFF);

        // Parameter sweep instances.
        sweep_one(12'h800, 16'hA5C3, 2'd0);
        chk("p12_800_m0", p12_out_imm, 32'hFFFFF800);
        chk("p16_m0_pass", 32'(p16_out_imm), 32'h0000A5C3);
        sweep_one(12'h800, 16'hA5C3, 2'd3);
        chk("p12_800_m3", p12_out_imm, 32'h80000000);
        chk("p16_m3_pass", 32'(p16_out_imm), 32'h0000A5C3);
        sweep_one(12'h800, 16'hA5C3, 2'd1);
        chk("p16_m1_pass", 32'(p16_out_imm), 32'h0000A5C3);
        sweep_one(12'h800, 16'hA5C3, 2'd2);
        chk("p16_m2_shl", 32'(p16_out_imm), 32'h0000970C);
        for (int i = 0; i < 20; i++)
            sweep_one(12'($urandom), 16'($urandom), 2'($urandom));

        // Streaming, 100 back-to-back.
        Out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            In_valid = 1'b1;
            In_imm   = 16'($urandom);
            In_mode  = 2'($urandom);
            last_exp = ref_ext(IN_W, OUT_W, longint'(In_imm), int'(In_mode));
            step(acc);
            chk("stream_accept", 32'(acc), 32'd1);
            chk("stream_valid", 32'(Out_valid), 32'd1);
            chk("stream_lat", Out_imm, last_exp);
        end
        In_valid = 1'b0;
        repeat (3) step(acc);

        // Back-pressure after two accepts.
        Out_ready = 1'b0;
        In_valid  = 1'b1;
        In_imm    = 16'h1234;
        In_mode   = 2'd0;
        step(acc);
        In_imm    = 16'hF00F;
        In_mode   = 2'd1;
        step(acc);
        chk("bp_in_ready", 32'(In_ready), 32'd0);
        chk("bp_first", Out_imm, 32'h00001234);
        In_imm  = 16'h5555;
        In_mode = 2'd3;
        repeat (3) step(acc);
        chk("bp_still_first", Out_imm, 32'h00001234);
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        step(acc);
        chk("bp_release_ready", 32'(In_ready), 32'd1);
        chk("bp_second", Out_imm, 32'h0000F00F);
        repeat (3) step(acc);
        chk("bp_drained", 32'(sb_q.size()), 32'd0);

        // Reset while FULL.
        Out_ready = 1'b0;
        In_valid  = 1'b1;
        In_imm    = 16'hBEEF;
        step(acc);
        In_imm    = 16'hCAFE;
        step(acc);
        In_valid = 1'b0;
        chk("pre_rst_full", 32'(In_ready), 32'd0);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(Out_valid), 32'd0);
        chk("midrst_imm", Out_imm, 32'd0);
        chk("midrst_cnt", Out_cnt, 32'd0);
        sb_q.delete();
        n_xfer = 0;
        @(posedge Clk);
        #1;
        Rst_n     = 1'b1;
        Out_ready = 1'b1;
        chk("midrst_in_ready", 32'(In_ready), 32'd1);
        step(acc);
        chk("midrst_no_replay", 32'(Out_valid), 32'd0);

        // Random valid/ready toggling with a holding producer.
        hold = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!hold) begin
                In_valid = 1'($urandom_range(0, 1));
                In_imm   = 16'($urandom);
                In_mode  = 2'($urandom);
            end
            Out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            hold = In_valid && !acc;
        end
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        repeat (5) step(acc);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("final_out_valid", 32'(Out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
